// File: rtl/spi_handler.sv
// SPI master for the thermostat flash (cs_n[1]) and TMP125 thermometer (cs_n[0]).
// Define FLASH_FAST_READ_EN to use the 0x0B fast-read command with one dummy byte.
module spi_handler #(
  parameter int unsigned PROGRAM_BYTES = 2112,
  parameter int unsigned CLK_DIV       = 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_read_program,
  output logic [8*PROGRAM_BYTES-1:0]   o_program_data,
  output logic                         o_program_ready,
  input  logic                         i_read_therm,
  output logic [9:0]                   o_temperature,
  output logic                         o_therm_ready,
  input  logic                         i_spi_disconnect,
  output logic                         o_spi_clk,
  output logic [1:0]                   o_spi_cs_n,
  output logic                         o_spi_si,
  input  logic                         i_spi_so
);

  localparam int unsigned DATA_BITS = 8 * PROGRAM_BYTES;
`ifdef FLASH_FAST_READ_EN
  localparam int unsigned CMD_BITS = 40;
  localparam logic [CMD_BITS-1:0] CMD_WORD = {8'h0B, 24'h000000, 8'h00};
`else
  localparam int unsigned CMD_BITS = 32;
  localparam logic [CMD_BITS-1:0] CMD_WORD = {8'h03, 24'h000000};
`endif
  localparam int unsigned CNT_W = $clog2(DATA_BITS > 64 ? DATA_BITS : 64);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] THERM_LAST = CNT_W'(15);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, FLASH_CMD, FLASH_DATA, THERM_DATA, DONE_P, DONE_T, WAIT_DISC
  } state_e;

  state_e                     state_q, state_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [CNT_W-1:0]           bit_q, bit_d;
  logic                       tail_q, tail_d;
  logic                       sck_q, sck_d;
  logic [1:0]                 cs_n_q, cs_n_d;
  logic                       si_q, si_d;
  logic [CMD_BITS-1:0]        cmd_q, cmd_d;
  logic [14:0]                therm_sh_q, therm_sh_d;
  logic [9:0]                 temp_q, temp_d;
  logic [DATA_BITS-1:0]       prog_q, prog_d;
  logic                       prog_rdy_q, prog_rdy_d;
  logic                       therm_rdy_q, therm_rdy_d;
  logic                       abort_flash_q, abort_flash_d;
  logic                       tick, start_flash, start_therm;
  logic [CNT_W-1:0]           wr_idx;

  // Bytes arrive MSB first: data bit k of byte n lands at 8n + (7 - k).
  assign wr_idx = {bit_q[CNT_W-1:3], ~bit_q[2:0]};
  assign tick   = (div_q == DIV_LAST);

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    bit_d         = bit_q;
    tail_d        = tail_q;
    sck_d         = sck_q;
    cs_n_d        = cs_n_q;
    si_d          = si_q;
    cmd_d         = cmd_q;
    therm_sh_d    = therm_sh_q;
    temp_d        = temp_q;
    prog_d        = prog_q;
    prog_rdy_d    = prog_rdy_q;
    therm_rdy_d   = therm_rdy_q;
    abort_flash_d = abort_flash_q;
    start_flash   = 1'b0;
    start_therm   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!i_spi_disconnect) begin
          if (i_read_therm && !therm_rdy_q)         start_therm = 1'b1;
          else if (i_read_program && !prog_rdy_q)   start_flash = 1'b1;
        end
      end
      FLASH_CMD, FLASH_DATA, THERM_DATA: begin
        if (i_spi_disconnect) begin
          state_d       = WAIT_DISC;
          cs_n_d        = '1;
          sck_d         = 1'b0;
          si_d          = 1'b0;
          bit_d         = '0;
          div_d         = '0;
          tail_d        = 1'b0;
          abort_flash_d = (state_q != THERM_DATA);
        end else begin
          div_d = tick ? '0 : div_q + 1'b1;
          if (tick) begin
            // tail_q: last SCK fall done, release chip select half a period later
            if (tail_q) begin
              tail_d = 1'b0;
              cs_n_d = '1;
              if (state_q == THERM_DATA) begin
                state_d     = DONE_T;
                therm_rdy_d = 1'b1;
                temp_d      = therm_sh_q[14:5];
              end else begin
                state_d    = DONE_P;
                prog_rdy_d = 1'b1;
              end
            end else if (!sck_q) begin
              sck_d = 1'b1;
              if (state_q == THERM_DATA)      therm_sh_d = {therm_sh_q[13:0], i_spi_so};
              else if (state_q == FLASH_DATA) prog_d[wr_idx] = i_spi_so;
            end else begin
              sck_d = 1'b0;
              if (state_q == FLASH_CMD) begin
                if (bit_q == CMD_LAST) begin
                  state_d = FLASH_DATA;
                  bit_d   = '0;
                  si_d    = 1'b0;
                end else begin
                  bit_d = bit_q + 1'b1;
                  cmd_d = cmd_q << 1;
                  si_d  = cmd_q[CMD_BITS-2];
                end
              end else if (bit_q == ((state_q == THERM_DATA) ? THERM_LAST : DATA_LAST)) begin
                tail_d = 1'b1;
              end else begin
                bit_d = bit_q + 1'b1;
              end
            end
          end
        end
      end
      DONE_P: begin
        if (!i_read_program) begin
          prog_rdy_d = 1'b0;
          state_d    = IDLE;
        end
      end
      DONE_T: begin
        if (!i_read_therm) begin
          therm_rdy_d = 1'b0;
          state_d     = IDLE;
        end
      end
      WAIT_DISC: begin
        if (!i_spi_disconnect) begin
          if (abort_flash_q) begin
            if (i_read_program) start_flash = 1'b1;
            else                state_d     = IDLE;
          end else begin
            if (i_read_therm)   start_therm = 1'b1;
            else                state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_therm) begin
      state_d = THERM_DATA;
      cs_n_d  = 2'b10;
      sck_d   = 1'b0;
      si_d    = 1'b0;
      bit_d   = '0;
      div_d   = '0;
      tail_d  = 1'b0;
    end
    if (start_flash) begin
      state_d = FLASH_CMD;
      cs_n_d  = 2'b01;
      sck_d   = 1'b0;
      cmd_d   = CMD_WORD;
      si_d    = CMD_WORD[CMD_BITS-1];
      bit_d   = '0;
      div_d   = '0;
      tail_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      div_q         <= '0;
      bit_q         <= '0;
      tail_q        <= 1'b0;
      sck_q         <= 1'b0;
      cs_n_q        <= '1;
      si_q          <= 1'b0;
      cmd_q         <= '0;
      therm_sh_q    <= '0;
      temp_q        <= '0;
      prog_q        <= '0;
      prog_rdy_q    <= 1'b0;
      therm_rdy_q   <= 1'b0;
      abort_flash_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      tail_q        <= tail_d;
      sck_q         <= sck_d;
      cs_n_q        <= cs_n_d;
      si_q          <= si_d;
      cmd_q         <= cmd_d;
      therm_sh_q    <= therm_sh_d;
      temp_q        <= temp_d;
      prog_q        <= prog_d;
      prog_rdy_q    <= prog_rdy_d;
      therm_rdy_q   <= therm_rdy_d;
      abort_flash_q <= abort_flash_d;
    end
  end

  assign o_program_data  = prog_q;
  assign o_program_ready = prog_rdy_q;
  assign o_temperature   = temp_q;
  assign o_therm_ready   = therm_rdy_q;
  assign o_spi_clk       = sck_q;
  assign o_spi_cs_n      = cs_n_q;
  assign o_spi_si        = si_q;

endmodule

// File: tb/tb_spi_handler.sv
// Directed bench for spi_handler with behavioural flash and TMP125 slave models.
module tb_spi_handler;

  localparam int PB        = 2112;
  localparam int DATA_BITS = 8 * PB;
`ifdef FLASH_FAST_READ_EN
  localparam int CMD_BITS = 40;
  localparam logic [39:0] EXP_CMD = {8'h0B, 24'h000000, 8'h00};
`else
  localparam int CMD_BITS = 32;
  localparam logic [39:0] EXP_CMD = {8'h00, 8'h03, 24'h000000};
`endif

  logic                  i_clk, i_reset, i_read_program, i_read_therm, i_spi_disconnect;
  logic [DATA_BITS-1:0]  o_program_data;
  logic                  o_program_ready, o_therm_ready, o_spi_clk, o_spi_si, spi_so;
  logic [9:0]            o_temperature;
  logic [1:0]            o_spi_cs_n, cs_eff;

  spi_handler #(.PROGRAM_BYTES(PB), .CLK_DIV(1)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_read_program(i_read_program), .o_program_data(o_program_data),
    .o_program_ready(o_program_ready),
    .i_read_therm(i_read_therm), .o_temperature(o_temperature),
    .o_therm_ready(o_therm_ready),
    .i_spi_disconnect(i_spi_disconnect), .o_spi_clk(o_spi_clk),
    .o_spi_cs_n(o_spi_cs_n), .o_spi_si(o_spi_si), .i_spi_so(spi_so)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Slave models: pull-ups force both selects high while disconnected.
  assign cs_eff = o_spi_cs_n | {2{i_spi_disconnect}};

  logic [DATA_BITS-1:0] flash_img;
  logic [15:0]          therm_word = 16'h0000;
  int unsigned          t_cnt = 0, t_last = 0, f_cnt = 0, f_ncmd = 0, f_low = 0, stray = 0;
  logic [39:0]          f_sh = '0, f_cmd = '0;
  logic                 prev_sck = 1'b0;

  always @(negedge i_clk) begin
    if (cs_eff[0]) begin
      if (t_cnt != 0) t_last = t_cnt;
      t_cnt = 0;
    end else if (o_spi_clk && !prev_sck) begin
      t_cnt++;
    end
    if (cs_eff[1]) begin
      f_cnt = 0;
      f_sh  = '0;
    end else begin
      f_low++;
      if (o_spi_clk && !prev_sck) begin
        if (f_cnt < CMD_BITS) begin
          f_sh = {f_sh[38:0], o_spi_si};
          if (f_cnt == CMD_BITS - 1) begin
            f_cmd = f_sh;
            f_ncmd++;
          end
        end
        f_cnt++;
      end
    end
    if (o_spi_cs_n == 2'b11 && o_spi_clk) stray++;
    prev_sck = o_spi_clk;
  end

  always_comb begin
    int unsigned b;
    spi_so = 1'b0;
    b      = 0;
    if (!cs_eff[0]) begin
      if (t_cnt < 16) spi_so = therm_word[15 - t_cnt];
    end else if (!cs_eff[1] && f_cnt >= CMD_BITS && f_cnt < CMD_BITS + DATA_BITS) begin
      b      = (f_cnt - CMD_BITS) ^ 7;
      spi_so = flash_img[b];
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_image(input string name);
    int first;
    checks++;
    if (o_program_data !== flash_img) begin
      failures++;
      first = -1;
      for (int n = PB - 1; n >= 0; n--)
        if (o_program_data[8*n +: 8] !== flash_img[8*n +: 8]) first = n;
      $display("FAIL %s: byte %0d got %0h expected %0h", name, first,
               o_program_data[8*first +: 8], flash_img[8*first +: 8]);
    end
  endtask

  task automatic load_image(input int seed);
    for (int n = 0; n < PB; n++) flash_img[8*n +: 8] = 8'((n * seed + (n >> 3) + seed * 17) & 255);
  endtask

  task automatic wait_therm(input int max, output logic ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < max) begin
      @(negedge i_clk);
      n++;
      if (o_therm_ready) ok = 1'b1;
    end
  endtask

  task automatic wait_prog(input int max, output logic ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < max) begin
      @(negedge i_clk);
      n++;
      if (o_program_ready) ok = 1'b1;
    end
  endtask

  task automatic therm_txn(input logic [15:0] word, input logic [9:0] exp);
    logic ok;
    therm_word = word;
    @(negedge i_clk);
    i_read_therm = 1'b1;
    wait_therm(200, ok);
    check("therm_done", ok, 1);
    check("therm_temp", o_temperature, exp);
    repeat (3) @(negedge i_clk);
    check("therm_hold_ready", o_therm_ready, 1);
    check("therm_hold_temp", o_temperature, exp);
    check("therm_rises", t_last, 16);
    check("therm_cs_idle", o_spi_cs_n, 2'b11);
    i_read_therm = 1'b0;
    @(negedge i_clk);
    check("therm_ready_clr", o_therm_ready, 0);
  endtask

  typedef struct {
    logic [15:0] word;
    logic [9:0]  temp;
  } tvec_t;

  tvec_t tv[6];

  initial begin
    logic ok;
    int unsigned nc0, fl0;

    // slave word -> expected temperature (bits 14:5)
    tv[0] = '{16'h0C80, 10'h064};  // 25.00 C
    tv[1] = '{16'h0C9F, 10'h064};  // low junk bits ignored
    tv[2] = '{16'h8C80, 10'h064};  // leading bit ignored
    tv[3] = '{16'h7FF5, 10'h3FF};  // -0.25 C
    tv[4] = '{16'h648A, 10'h324};  // -55.00 C
    tv[5] = '{16'h3FE0, 10'h1FF};  // 127.75 C

    load_image(1);
    i_reset = 1'b1; i_read_program = 1'b0; i_read_therm = 1'b0; i_spi_disconnect = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_cs", o_spi_cs_n, 2'b11);
    check("rst_sck", o_spi_clk, 0);
    check("rst_si", o_spi_si, 0);
    check("rst_prdy", o_program_ready, 0);
    check("rst_trdy", o_therm_ready, 0);
    check("rst_temp", o_temperature, 0);
    check("rst_prog", (o_program_data == '0) ? 1 : 0, 1);
    i_reset = 1'b0;
    repeat (20) @(negedge i_clk);
    check("idle_cs", o_spi_cs_n, 2'b11);
    check("idle_stray", stray, 0);
    check("idle_flash_cs", f_low, 0);
    check("idle_rises", t_last, 0);

    for (int i = 0; i < 6; i++) therm_txn(tv[i].word, tv[i].temp);

    // Thermometer, then program one clock later: flash waits for therm release
    load_image(3);
    nc0 = f_ncmd; fl0 = f_low;
    therm_word = 16'h0C80;
    @(negedge i_clk); i_read_therm = 1'b1;
    @(negedge i_clk); i_read_program = 1'b1;
    wait_therm(200, ok);
    check("prio_therm_done", ok, 1);
    check("prio_temp", o_temperature, 10'h064);
    repeat (10) @(negedge i_clk);
    check("prio_flash_held", f_low - fl0, 0);
    check("prio_cs", o_spi_cs_n, 2'b11);
    check("prio_prdy", o_program_ready, 0);
    i_read_therm = 1'b0;
    @(negedge i_clk);
    check("prio_trdy_clr", o_therm_ready, 0);
    @(negedge i_clk);
    check("prio_flash_cs", o_spi_cs_n, 2'b01);
    wait_prog(40000, ok);
    check("prog_done", ok, 1);
    check_image("prog_image");
    repeat (2) @(negedge i_clk);
    check("prog_cmd", f_cmd, EXP_CMD);
    check("prog_ncmd", f_ncmd - nc0, 1);
    check("prog_hold_ready", o_program_ready, 1);
    i_read_program = 1'b0;
    @(negedge i_clk);
    check("prog_ready_clr", o_program_ready, 0);

    // Disconnect 11 clocks into a flash read
    load_image(5);
    nc0 = f_ncmd;
    @(negedge i_clk); i_read_program = 1'b1;
    repeat (11) @(negedge i_clk);
    i_spi_disconnect = 1'b1;
    @(negedge i_clk);
    check("fdisc_cs", o_spi_cs_n, 2'b11);
    check("fdisc_sck", o_spi_clk, 0);
    repeat (49) @(negedge i_clk);
    check("fdisc_cs_held", o_spi_cs_n, 2'b11);
    check("fdisc_prdy", o_program_ready, 0);
    i_spi_disconnect = 1'b0;
    wait_prog(40000, ok);
    check("fdisc_done", ok, 1);
    check_image("fdisc_image");
    repeat (2) @(negedge i_clk);
    check("fdisc_cmd", f_cmd, EXP_CMD);
    check("fdisc_ncmd", f_ncmd - nc0, 1);
    i_read_program = 1'b0;
    @(negedge i_clk);
    check("fdisc_ready_clr", o_program_ready, 0);

    // Disconnect 10 clocks into a thermometer read, then a disconnect while DONE_T
    therm_word = 16'h648A;
    @(negedge i_clk); i_read_therm = 1'b1;
    repeat (10) @(negedge i_clk);
    i_spi_disconnect = 1'b1;
    @(negedge i_clk);
    check("tdisc_cs", o_spi_cs_n, 2'b11);
    repeat (49) @(negedge i_clk);
    check("tdisc_trdy", o_therm_ready, 0);
    i_spi_disconnect = 1'b0;
    wait_therm(200, ok);
    check("tdisc_done", ok, 1);
    check("tdisc_temp", o_temperature, 10'h324);
    i_spi_disconnect = 1'b1;
    repeat (3) @(negedge i_clk);
    check("done_disc_ready", o_therm_ready, 1);
    check("done_disc_temp", o_temperature, 10'h324);
    check("tdisc_rises", t_last, 16);
    i_spi_disconnect = 1'b0;
    i_read_therm = 1'b0;
    @(negedge i_clk);
    check("tdisc_ready_clr", o_therm_ready, 0);

    // Request dropped mid-transfer: completes, ready for one clock
    therm_word = 16'h7FF5;
    @(negedge i_clk); i_read_therm = 1'b1;
    repeat (5) @(negedge i_clk);
    i_read_therm = 1'b0;
    wait_therm(200, ok);
    check("drop_done", ok, 1);
    check("drop_temp", o_temperature, 10'h3FF);
    @(negedge i_clk);
    check("drop_ready_clr", o_therm_ready, 0);

    // Reset mid flash transfer
    @(negedge i_clk); i_read_program = 1'b1;
    repeat (20) @(negedge i_clk);
    check("mid_active", o_spi_cs_n, 2'b01);
    i_reset = 1'b1;
    #1;
    check("mid_rst_cs", o_spi_cs_n, 2'b11);
    check("mid_rst_sck", o_spi_clk, 0);
    check("mid_rst_temp", o_temperature, 0);
    check("mid_rst_prog", (o_program_data == '0) ? 1 : 0, 1);
    i_read_program = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (5) @(negedge i_clk);
    check("end_stray", stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
